spi_master_tx: RTL and testbench

//  SPI master transmitter. Generates s_clk, cs and mosi that drive the team's SPI slave receiver.

---
 rtl/spi_master_tx.sv | 103 ++++++++++
 tb/tb_spi_master_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI master transmitter, one LSB-first DATA_W-bit word per frame (lead pulse, data pulses, trail pulse)
// Ports:
//   clk      system clock, all logic on posedge
//   rst      asynchronous active-low reset
//   start    frame request, sampled only while ready=1
//   data_in  word to send, captured on the accept edge
//   ready    idle, a start will be accepted
//   busy     frame in progress (~ready)
//   done     one-cycle pulse at frame end
//   s_clk    SPI clock, idles low, rising edge is the slave sample edge
//   cs       chip select, active low, idles high
//   mosi     serial data, changes only on the edge where s_clk goes low
module spi_master_tx #(
    parameter int DATA_W  = 11,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              cs,
    output logic              mosi
);
    localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [HW-1:0] HC_MAX = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BC_MAX = BW'(DATA_W);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [HW-1:0]     hc;
    logic [BW-1:0]     bc;
    logic              half_end;
    logic              pulse_end;

    assign busy      = ~ready;
    assign half_end  = hc == HC_MAX;
    // the high half of a pulse is ending: s_clk falls and the next pulse starts
    assign pulse_end = s_clk && half_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            s_clk <= 1'b0;
            cs    <= 1'b1;
            mosi  <= 1'b0;
            sr    <= '0;
            hc    <= '0;
            bc    <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= LEAD;
                    ready <= 1'b0;
                    cs    <= 1'b0;
                    mosi  <= 1'b0;
                    sr    <= data_in;
                    hc    <= '0;
                    bc    <= '0;
                end
            end else begin
                hc <= half_end ? '0 : hc + 1'b1;
                if (half_end)
                    s_clk <= ~s_clk;
                if (pulse_end) begin
                    case (state)
                        LEAD: begin
                            state <= SHIFT;
                            mosi  <= sr[0];
                            sr    <= sr >> 1;
                            bc    <= BW'(1);
                        end
                        SHIFT: begin
                            if (bc == BC_MAX) begin
                                state <= TRAIL;
                                cs    <= 1'b1;
                                mosi  <= 1'b0;
                            end else begin
                                mosi <= sr[0];
                                sr   <= sr >> 1;
                                bc   <= bc + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            ready <= 1'b1;
                            done  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: randomized self-checking bench for spi_master_tx at CLK_DIV=2 and CLK_DIV=1
module tb_spi_master_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [10:0] data_in = '0;
    logic        ready_a, busy_a, done_a, s_clk_a, cs_a, mosi_a;
    logic        ready_b, busy_b, done_b, s_clk_b, cs_b, mosi_b;
    logic        ready, busy, done, s_clk, cs, mosi;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    spi_master_tx #(.DATA_W(11), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .data_in(data_in),
        .ready(ready_a), .busy(busy_a), .done(done_a), .s_clk(s_clk_a), .cs(cs_a), .mosi(mosi_a)
    );

    spi_master_tx #(.DATA_W(11), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .data_in(data_in),
        .ready(ready_b), .busy(busy_b), .done(done_b), .s_clk(s_clk_b), .cs(cs_b), .mosi(mosi_b)
    );

    assign ready = sel ? ready_b : ready_a;
    assign busy  = sel ? busy_b  : busy_a;
    assign done  = sel ? done_b  : done_a;
    assign s_clk = sel ? s_clk_b : s_clk_a;
    assign cs    = sel ? cs_b    : cs_a;
    assign mosi  = sel ? mosi_b  : mosi_a;

    // Drives one frame and reconstructs what a slave would see at each rising s_clk.
    // Returns in the done cycle (#1 after the edge) so a caller can chain a back-to-back start.
    task automatic run_frame(input logic [10:0] d, input logic keep, input int late_rise, input logic [10:0] d_late);
        int          n, rises, cd, stab;
        logic [12:0] cs_seq, mo_seq, exp_mo;
        logic        ps, pc, pm, got;
        cd = sel ? 1 : 2;
        exp_mo = {1'b0, d, 1'b0};
        data_in = d;
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1 || cs !== 1'b0 || s_clk !== 1'b0 || mosi !== 1'b0) begin
            errors++;
            $display("FAIL accept: ready=%b busy=%b cs=%b s_clk=%b mosi=%b, required 0 1 0 0 0", ready, busy, cs, s_clk, mosi);
        end
        start = keep;
        data_in = 11'($urandom);
        n = 0; rises = 0; got = 1'b0; stab = 0; cs_seq = '0; mo_seq = '0;
        ps = s_clk; pc = cs; pm = mosi;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) got = 1'b1;
            else begin
                if ((cs !== pc || mosi !== pm) && !(ps && !s_clk)) stab++;
                if (s_clk && !ps) begin
                    if (rises < 13) begin
                        cs_seq[rises] = cs;
                        mo_seq[rises] = mosi;
                    end
                    rises++;
                    if (rises == late_rise) begin
                        start = 1'b1;
                        data_in = d_late;
                    end
                end else start = keep;
            end
            ps = s_clk; pc = cs; pm = mosi;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles, required at %0d", n, 26 * cd);
        end
        checks++;
        if (n != 26 * cd) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles, required %0d", n, 26 * cd);
        end
        checks++;
        if (rises != 13) begin
            errors++;
            $display("FAIL rise_count: got %0d, required 13", rises);
        end
        checks++;
        if (cs_seq !== 13'h1000) begin
            errors++;
            $display("FAIL cs_at_rises: got %h, required 1000", cs_seq);
        end
        checks++;
        if (mo_seq !== exp_mo) begin
            errors++;
            $display("FAIL mosi_at_rises: got %h, required %h (word %h)", mo_seq, exp_mo, d);
        end
        checks++;
        if (mo_seq[11:1] !== d) begin
            errors++;
            $display("FAIL slave_word: got %h, required %h", mo_seq[11:1], d);
        end
        checks++;
        if (stab != 0) begin
            errors++;
            $display("FAIL pin_stability: %0d changes outside the s_clk falling edge, required 0", stab);
        end
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || s_clk !== 1'b0 || cs !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle: ready=%b busy=%b s_clk=%b cs=%b, required 1 0 0 1", ready, busy, s_clk, cs);
        end
        if (!keep) begin
            start = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL done_pulse_width: done=%b ready=%b, required 0 1", done, ready);
            end
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || s_clk !== 1'b0 || cs !== 1'b1 || mosi !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b s_clk=%b cs=%b mosi=%b, required 1 0 0 0 1 0",
                     ready, busy, done, s_clk, cs, mosi);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        run_frame(11'h5A5, 1'b0, -1, 11'h000);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++)
            run_frame(11'($urandom), 1'b0, int'($urandom_range(2, 12)), 11'($urandom));
    endtask

    task automatic test_loopback;
        run_frame(11'h000, 1'b0, -1, 11'h000);
        run_frame(11'h7FF, 1'b0, -1, 11'h000);
        run_frame(11'h401, 1'b0, -1, 11'h000);
    endtask

    task automatic test_busy_ignore;
        run_frame(11'h123, 1'b0, 4, 11'h3FF);
    endtask

    task automatic test_back_to_back;
        run_frame(11'h0AA, 1'b1, -1, 11'h000);
        run_frame(11'h555, 1'b0, -1, 11'h000);
    endtask

    task automatic test_reset_mid;
        int  rises, n;
        logic ps, seen_done;
        data_in = 11'h2AB;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rises = 0; n = 0; ps = s_clk;
        while (rises < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (s_clk && !ps) rises++;
            ps = s_clk;
        end
        checks++;
        if (rises != 5) begin
            errors++;
            $display("FAIL mid_reach: got %0d rises, required 5", rises);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (cs !== 1'b1 || s_clk !== 1'b0 || mosi !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cs=%b s_clk=%b mosi=%b ready=%b busy=%b done=%b, required 1 0 0 1 0 0",
                     cs, s_clk, mosi, ready, busy, done);
        end
        seen_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        rst = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: done seen=%b, required 0", seen_done);
        end
        run_frame(11'h2D3, 1'b0, -1, 11'h000);
    endtask

    task automatic test_clkdiv1;
        sel = 1'b1;
        run_frame(11'h001, 1'b0, -1, 11'h000);
        run_frame(11'($urandom), 1'b0, 3, 11'($urandom));
        run_frame(11'($urandom), 1'b1, -1, 11'h000);
        run_frame(11'($urandom), 1'b0, -1, 11'h000);
        sel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_random;
        test_loopback;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_clkdiv1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
